// File: rtl/poly_addsub_seq.sv
// poly_addsub_seq
//   Streams two N-coefficient polynomials out of a pair of source RAMs,
//   presents them as operand pairs to an external mod_add pipeline, and
//   writes the reduced results back to a destination RAM in order.
//   mode 0 computes a+b, mode 1 computes a-b (mod Q) by feeding Q-b as the
//   second operand, so a single mod_add instance serves both operations.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start_i, mode_i : start request (accepted only in IDLE), 0=add / 1=sub
//   busy_o, done_o  : high during RUN/DRAIN, one-cycle completion pulse
//   rd_en_o, rd_addr_o, a_i, b_i : source RAM read port (1-cycle latency)
//   op1_o, op2_o, add_valid_o    : operand pair to mod_add
//   add_result_i, add_valid_i    : result stream from mod_add
//   wr_en_o, wr_addr_o, wr_data_o: destination RAM write port
module poly_addsub_seq #(
  parameter int N      = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [11:0]       a_i,
  input  logic [11:0]       b_i,
  output logic [11:0]       op1_o,
  output logic [11:0]       op2_o,
  output logic              add_valid_o,
  input  logic [11:0]       add_result_i,
  input  logic              add_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o
);

  // Modulus shared with poly_arith_pkg (Kyber Q).
  localparam logic [11:0] Q = 12'd3329;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              mode_q, mode_d;
  logic              add_valid_q, add_valid_d;

  logic run_s;
  logic busy_s;
  logic wr_fire;

  assign run_s  = (state_q == S_RUN);
  assign busy_s = run_s | (state_q == S_DRAIN);
  // Results are only accepted while a run is in progress; anything arriving
  // in IDLE/DONE is a stale pipeline leftover. Gating with rst keeps the
  // reset cycle itself free of writes.
  assign wr_fire = add_valid_i & busy_s & ~rst;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mode_d      = mode_q;
    add_valid_d = run_s;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          mode_d   = mode_i;
        end
      end
      S_RUN: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Completion is keyed on the last accepted result, not on a fixed
        // mod_add latency.
        if (wr_fire && (wr_cnt_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      mode_q      <= 1'b0;
      add_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      mode_q      <= mode_d;
      add_valid_q <= add_valid_d;
    end
  end

  assign busy_o    = busy_s;
  assign done_o    = (state_q == S_DONE);
  assign rd_en_o   = run_s;
  assign rd_addr_o = run_s ? rd_cnt_q : '0;

  // b==0 must map to 0, not Q, so the operand stays reduced.
  assign op1_o       = a_i;
  assign op2_o       = mode_q ? ((b_i == 12'd0) ? 12'd0 : (Q - b_i)) : b_i;
  assign add_valid_o = add_valid_q;

  assign wr_en_o   = wr_fire;
  assign wr_addr_o = wr_cnt_q;
  assign wr_data_o = add_result_i;

endmodule

// File: tb/tb_poly_addsub_seq.sv
// Testbench for poly_addsub_seq: source RAMs and a 2-cycle mod_add are
// modelled around the DUT. Expected writes (address, data, cycle) and the
// expected done cycle are queued at each start from plain modular arithmetic;
// a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_poly_addsub_seq;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int Q  = 3329;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mode_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [11:0]   a_i = '0;
  logic [11:0]   b_i = '0;
  logic [11:0]   op1_o;
  logic [11:0]   op2_o;
  logic          add_valid_o;
  logic [11:0]   add_result_i;
  logic          add_valid_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [11:0]   wr_data_o;

  poly_addsub_seq #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .a_i(a_i), .b_i(b_i),
    .op1_o(op1_o), .op2_o(op2_o), .add_valid_o(add_valid_o),
    .add_result_i(add_result_i), .add_valid_i(add_valid_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAMs, 1-cycle read latency.
  int mem_a [N];
  int mem_b [N];
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_i <= 12'(mem_a[rd_addr_o]);
      b_i <= 12'(mem_b[rd_addr_o]);
    end
  end

  // mod_add environment model, 2-cycle latency, keeps running through reset.
  logic        m1_v = 1'b0, m2_v = 1'b0, stray_v = 1'b0;
  logic [11:0] m1_r = '0, m2_r = '0;
  always @(posedge clk) begin
    m1_v <= add_valid_o;
    m1_r <= 12'((int'(op1_o) + int'(op2_o)) % Q);
    m2_v <= m1_v;
    m2_r <= m1_r;
  end
  assign add_valid_i  = m2_v | stray_v;
  assign add_result_i = m2_r;

  typedef struct {
    int addr;
    int data;
    int when;
  } wr_t;
  wr_t wq[$];
  int  dq[$];
  wr_t e_w;
  int  e_d;

  int checks = 0;
  int errors = 0;
  int busy_from = -1;
  int busy_to = -1;

  // Monitor: compares every write, every done pulse and busy_o each cycle.
  always @(negedge clk) begin
    if (wr_en_o) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%0d, required no write",
                 cyc, wr_addr_o, wr_data_o);
      end else begin
        e_w = wq.pop_front();
        if (wr_addr_o !== AW'(e_w.addr) || wr_data_o !== 12'(e_w.data) || cyc != e_w.when) begin
          errors++;
          $display("FAIL write cyc=%0d got addr=%0d data=%0d, required addr=%0d data=%0d cyc=%0d",
                   cyc, wr_addr_o, wr_data_o, e_w.addr, e_w.data, e_w.when);
        end
      end
    end
    if (done_o) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done=1, required done=0", cyc);
      end else begin
        e_d = dq.pop_front();
        if (cyc != e_d || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL done cyc=%0d busy=%0b, required cyc=%0d busy=0", cyc, busy_o, e_d);
        end
      end
    end
    checks++;
    if (busy_o !== ((cyc >= busy_from) && (cyc <= busy_to))) begin
      errors++;
      $display("FAIL busy cyc=%0d got %0b, required %0b", cyc, busy_o,
               (cyc >= busy_from) && (cyc <= busy_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_rd_en"}, int'(rd_en_o), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr_o), 0);
    chk({tag, "_add_valid"}, int'(add_valid_o), 0);
    chk({tag, "_wr_en"}, int'(wr_en_o), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr_o), 0);
  endtask

  // Called at posedge+1; start_i is sampled at the end of this cycle (E0),
  // so T0 is the next cycle.
  task automatic do_start(input bit m, output int t0);
    int d;
    start_i = 1'b1;
    mode_i  = m;
    t0      = cyc + 1;
    for (int k = 0; k < N; k++) begin
      d = m ? (mem_a[k] - mem_b[k] + Q) % Q : (mem_a[k] + mem_b[k]) % Q;
      wq.push_back('{k, d, t0 + k + 3});
    end
    dq.push_back(t0 + N + 3);
    busy_from = t0;
    busy_to   = t0 + N + 2;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending writes=%0d dones=%0d, required 0", name, wq.size(), dq.size());
    end
    $display("run %s complete at cyc=%0d", name, cyc);
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++) begin
      mem_a[k] = int'($urandom_range(Q - 1, 0));
      mem_b[k] = int'($urandom_range(Q - 1, 0));
    end
  endtask

  int t0;
  int t1;

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    for (int k = 0; k < N; k++) begin mem_a[k] = 0; mem_b[k] = 0; end
    repeat (3) tick();
    chk_idle_outs("reset");
    rst = 1'b0;
    tick();
    chk_idle_outs("post_reset");

    // Add, all zeros.
    do_start(1'b0, t0);
    wait_done("add_zeros");

    // Add with wrap; a flipped-mode start at T0+10 must be ignored, then a
    // back-to-back start at the earliest legal cycle.
    for (int k = 0; k < N; k++) begin mem_a[k] = Q - 1; mem_b[k] = k; end
    do_start(1'b0, t0);
    wait_cyc(t0 + 10);
    start_i = 1'b1; mode_i = 1'b1;
    tick();
    start_i = 1'b0; mode_i = 1'b0;
    wait_cyc(t0 + N + 4);
    chk("b2b_wrap_writes_left", wq.size(), 0);
    load_rand();
    do_start(1'b1, t1);
    wait_done("add_wrap_then_b2b_sub");

    // Subtract, mixed (b=0 path at index 0).
    for (int k = 0; k < N; k++) begin mem_a[k] = k; mem_b[k] = (k == 0) ? 0 : 5; end
    do_start(1'b1, t0);
    wait_done("sub_mixed");

    // Reset mid-run, stale results and a stray valid must not write.
    load_rand();
    do_start(1'b0, t0);
    wait_cyc(t0 + 100);
    rst = 1'b1;
    wq.delete();
    dq.delete();
    busy_to = cyc;
    tick();
    rst = 1'b0;
    chk_idle_outs("mid_reset");
    repeat (5) tick();
    stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    tick();
    chk("stray_wr_addr", int'(wr_addr_o), 0);
    $display("run reset_mid_run complete at cyc=%0d", cyc);

    // Fresh start after reset, random subtract.
    load_rand();
    do_start(1'b1, t0);
    wait_done("after_reset_sub");

    load_rand();
    do_start(1'b0, t0);
    wait_done("random_add");

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_addsub_seq.md
# poly_addsub_seq

Sequencer that streams two N-coefficient polynomials out of coefficient RAM through `mod_add` and writes the reduced result back to RAM. It sits directly upstream and downstream of `mod_add`:
- issues RAM reads and presents operand pairs with a valid strobe;
- collects `mod_add` results in order and generates the write-back addresses.

A mode bit selects addition (a+b) or subtraction (a−b mod Q). Subtraction is done by presenting Q−b as the second operand, so one `mod_add` instance serves both.

## Interface
Parameters:
- `N`, 256: coefficients per polynomial.
- `ADDR_W`, 8: RAM address width; `2**ADDR_W >= N`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: start request; sampled only in IDLE.
- `mode_i` in 1: 0 = add, 1 = subtract; latched when start is accepted.
- `busy_o` out 1: high in RUN and DRAIN.
- `done_o` out 1: one-cycle completion pulse.
- `rd_en_o` out 1: read strobe to both source RAMs (1-cycle read latency).
- `rd_addr_o` out ADDR_W: read address.
- `a_i` in 12 (`coeff_t`): source A data, valid the cycle after `rd_en_o`.
- `b_i` in 12 (`coeff_t`): source B data, same timing as `a_i`.
- `op1_o` out 12: to `mod_add` `op1_i`.
- `op2_o` out 12: to `mod_add` `op2_i`.
- `add_valid_o` out 1: to `mod_add` `valid_i`.
- `add_result_i` in 12: from `mod_add` `result_o`.
- `add_valid_i` in 1: from `mod_add` `valid_o`.
- `wr_en_o` out 1: destination RAM write strobe.
- `wr_addr_o` out ADDR_W: write address.
- `wr_data_o` out 12: write data.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `start_i=1` moves to RUN, clears `rd_cnt` and `wr_cnt`, and latches `mode_q`.
  - `start_i` is ignored in every other state.
- **RUN:**
  - `rd_en_o=1`, `rd_addr_o=rd_cnt`; `rd_cnt` increments every cycle.
  - When address N−1 is issued, move to DRAIN.
- **Operand stage (combinational from RAM data):**
  - `op1_o = a_i`.
  - `mode_q=0`: `op2_o = b_i`.
  - `mode_q=1`: `op2_o = (b_i==0) ? 0 : Q−b_i`, with Q=3329 from `poly_arith_pkg`.
  - `add_valid_o` is `rd_en_o` delayed one cycle by a register.
- **Write-back (combinational passthrough):**
  - `wr_en_o = add_valid_i & busy_o`.
  - `wr_data_o = add_result_i`.
  - `wr_addr_o = wr_cnt`; `wr_cnt` increments on every accepted result.
- **DRAIN:** when a result is accepted with `wr_cnt==N−1`, move to DONE.
- **DONE:** `done_o=1` and `busy_o=0` for exactly one cycle, then IDLE.
- **Ordering:** results are consumed strictly in order; `mod_add` latency is fixed, but the block relies only on `add_valid_i`, not on a hard-coded latency.
- **Input range:** inputs are assumed reduced (0..3328); Q−b_i lies in 1..3328 for b_i≠0.
- **Reset:** any state, including mid-RUN or mid-DRAIN, returns to IDLE. All outputs and counters go to 0, `mode_q=0`, and no write is issued in the reset cycle or after it.
- **Stray results:** `add_valid_i` pulses while IDLE or DONE (for example stale pipeline results after reset) produce no write and do not move `wr_cnt`.

## Timing
- Reset values: `busy_o`, `done_o`, `rd_en_o`, `add_valid_o`, `wr_en_o` = 0; `rd_addr_o`, `wr_addr_o` = 0; `op1_o`, `op2_o`, `wr_data_o` follow their inputs.
- Let E0 be the edge that samples `start_i=1` in IDLE, and T0 the following cycle.
- Read of coefficient k: cycle T0+k.
- Operands and `add_valid_o` for k: T0+k+1.
- `mod_add` result for k (2-cycle latency): T0+k+3; write of index k in the same cycle.
- Last write (k=N−1): T0+N+2.
- `done_o`: T0+N+3, i.e. T0+259 for N=256.
- `busy_o` is high from T0 through T0+N+2.
- Earliest accepted restart: `start_i` sampled in cycle T0+N+4 (back in IDLE).
- Throughput: one coefficient per cycle, with no bubbles between reads.

## Test plan
- **Add, all zeros:** after reset, A=B=0, `mode_i=0`, pulse start.
  - Writes to addresses 0..255 in cycles T0+3..T0+258, all data 0.
  - `done_o` only at T0+259; `busy_o` drops the same cycle.
- **Add, wrap:** A[k]=3328, B[k]=k, `mode_i=0`.
  - Write k = (3328+k) mod 3329: address 0 → 3328, address 1 → 0, address 255 → 254.
- **Subtract, mixed:** A[k]=k, B[k]=(k==0)?0:5, `mode_i=1`.
  - Address 0 → 0 (the b=0 path, `op2_o=0`); address 3 → 3327; address 5 → 0; address 200 → 195.
- **Start while busy:** pulse `start_i` again at T0+10 with `mode_i` flipped.
  - Run unaffected: exactly 256 writes, one `done_o`, and results use the original mode.
- **Reset mid-run:** assert `rst` at T0+100 for one cycle.
  - All outputs 0 from the next cycle; `mod_add` results still in flight produce no `wr_en_o`.
  - A new start completes normally with 256 writes starting at address 0.
- **Back-to-back:** a second start at T0+N+4 yields a second full run with correct timing relative to its own E0.
